// File: rtl/mc8051_mem_resp_pkg.sv
// Shared definitions for the mc8051 memory responder slice.
// Holds space/state encodings, SFR base, default wait and timeout
// values, the latched request struct and the request routing helper.
package mc8051_mem_resp_pkg;

  // Memory space tags carried with every request.
  localparam logic [1:0] MEM_SP_DIR   = 2'b00;
  localparam logic [1:0] MEM_SP_IND   = 2'b01;
  localparam logic [1:0] MEM_SP_CODE  = 2'b10;
  localparam logic [1:0] MEM_SP_XDATA = 2'b11;

  // Direct addresses at or above this value belong to the SFR bus.
  localparam logic [7:0] SFR_BASE = 8'h80;

  localparam int DEF_CODE_WAIT   = 1;
  localparam int DEF_XDATA_WAIT  = 2;
  localparam int DEF_EXT_TIMEOUT = 64;

  localparam int WAIT_W = 4;  // holds 0..15 wait states
  localparam int TMO_W  = 8;  // holds 1..255 timeout cycles

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IRAM = 3'd1,
    ST_SFR  = 3'd2,
    ST_EXT  = 3'd3,
    ST_RESP = 3'd4
  } mem_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  space;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_req_t;

  // Picks the servicing state for a request. Indirect accesses always
  // hit internal RAM (including the upper 128 bytes); direct accesses
  // split at SFR_BASE; code and xdata go to the external port.
  function automatic mem_state_e route_req(input logic [1:0]  space,
                                           input logic [15:0] addr);
    mem_state_e st;
    if (space[1]) begin
      st = ST_EXT;
    end else if ((space == MEM_SP_IND) || (addr[7:0] < SFR_BASE)) begin
      st = ST_IRAM;
    end else begin
      st = ST_SFR;
    end
    return st;
  endfunction

endpackage

// File: rtl/mc8051_ext_wait.sv
// Wait-state and timeout counters for an external bus access.
// Ports: i_load restarts both counters (wait <= i_load_val, timeout <= 0);
// i_en marks a bus cycle; o_done = wait count exhausted; o_timeout = this
// enabled cycle is the TIMEOUT-th since load (never when TIMEOUT == 0).
module mc8051_ext_wait
  import mc8051_mem_resp_pkg::*;
#(
  parameter int TIMEOUT = DEF_EXT_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_done,
  output logic              o_timeout
);

  // Count value seen during the last permitted cycle.
  localparam logic [TMO_W-1:0] TMO_LAST =
      (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q,  tmo_cnt_d;
  logic              tmo_hit;

  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST);
  assign o_done    = (wait_cnt_q == '0);
  assign o_timeout = i_en && tmo_hit;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (i_load) begin
      wait_cnt_d = i_load_val;
      tmo_cnt_d  = '0;
    end else if (i_en) begin
      if (wait_cnt_q != '0) begin
        wait_cnt_d = wait_cnt_q - 1'b1;
      end
      // Hold at the limit so a lingering enable cannot wrap the count.
      if (!tmo_hit) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/mc8051_mem_resp.sv
// Memory-side responder: completes one core request against internal
// RAM, the SFR bus or the external code/xdata port; ack at N+2 for
// IRAM/SFR, N+2+WAIT(+ready stretch) for external, with bus error on
// timeout or code-space write. Requests are only sampled while idle;
// o_mem_busy tells the sequencer to hold off.
// Ports: i_mem_* request in, o_mem_* ack/data out, o_iram_*/o_sfr_*/
// o_ext_* one-hot memory strobes, i_ext_rdy stretches external cycles.
module mc8051_mem_resp
  import mc8051_mem_resp_pkg::*;
#(
  parameter int CODE_WAIT   = DEF_CODE_WAIT,
  parameter int XDATA_WAIT  = DEF_XDATA_WAIT,
  parameter int EXT_TIMEOUT = DEF_EXT_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_req,
  input  logic        i_mem_wr,
  input  logic [1:0]  i_mem_space,
  input  logic [15:0] i_mem_addr,
  input  logic [7:0]  i_mem_wdata,
  output logic        o_mem_busy,
  output logic        o_mem_ack,
  output logic [7:0]  o_mem_rdata,
  output logic        o_bus_err,
  output logic [7:0]  o_iram_addr,
  output logic        o_iram_we,
  output logic        o_iram_re,
  output logic [7:0]  o_iram_wdata,
  input  logic [7:0]  i_iram_rdata,
  output logic [7:0]  o_sfr_addr,
  output logic        o_sfr_we,
  output logic        o_sfr_re,
  output logic [7:0]  o_sfr_wdata,
  input  logic [7:0]  i_sfr_rdata,
  output logic [15:0] o_ext_addr,
  output logic        o_ext_we,
  output logic        o_ext_re,
  output logic        o_ext_psen,
  output logic [7:0]  o_ext_wdata,
  input  logic [7:0]  i_ext_rdata,
  input  logic        i_ext_rdy
);

  mem_state_e state_q, state_d;
  mem_req_t   req_q,   req_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q,   err_d;

  logic              ew_load;
  logic [WAIT_W-1:0] ew_load_val;
  logic              ew_done;
  logic              ew_timeout;
  logic              ext_en;
  logic              is_code;
  logic              iram_rd;

  assign ext_en  = (state_q == ST_EXT);
  assign is_code = (req_q.space == MEM_SP_CODE);
  // Internal RAM data arrives one cycle after the strobe, i.e. in RESP,
  // so it is forwarded straight to the core there and captured as well.
  assign iram_rd = (route_req(req_q.space, req_q.addr) == ST_IRAM) && !req_q.wr;

  mc8051_ext_wait #(
    .TIMEOUT (EXT_TIMEOUT)
  ) u_ext_wait (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ew_load),
    .i_load_val (ew_load_val),
    .i_en       (ext_en),
    .o_done     (ew_done),
    .o_timeout  (ew_timeout)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    ew_load      = 1'b0;
    ew_load_val  = '0;
    o_mem_busy   = (state_q != ST_IDLE);
    o_mem_ack    = 1'b0;
    o_mem_rdata  = rdata_q;
    o_bus_err    = 1'b0;
    o_iram_addr  = '0;
    o_iram_we    = 1'b0;
    o_iram_re    = 1'b0;
    o_iram_wdata = '0;
    o_sfr_addr   = '0;
    o_sfr_we     = 1'b0;
    o_sfr_re     = 1'b0;
    o_sfr_wdata  = '0;
    o_ext_addr   = '0;
    o_ext_we     = 1'b0;
    o_ext_re     = 1'b0;
    o_ext_psen   = 1'b0;
    o_ext_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_mem_req) begin
          req_d.wr    = i_mem_wr;
          req_d.space = i_mem_space;
          req_d.addr  = i_mem_addr;
          req_d.wdata = i_mem_wdata;
          err_d       = 1'b0;
          state_d     = route_req(i_mem_space, i_mem_addr);
          if (i_mem_space[1]) begin
            ew_load     = 1'b1;
            ew_load_val = (i_mem_space == MEM_SP_CODE) ? WAIT_W'(CODE_WAIT)
                                                       : WAIT_W'(XDATA_WAIT);
          end
        end
      end

      ST_IRAM: begin
        o_iram_addr  = req_q.addr[7:0];
        o_iram_re    = !req_q.wr;
        o_iram_we    = req_q.wr;
        o_iram_wdata = req_q.wdata;
        state_d      = ST_RESP;
      end

      ST_SFR: begin
        o_sfr_addr  = req_q.addr[7:0];
        o_sfr_re    = !req_q.wr;
        o_sfr_we    = req_q.wr;
        o_sfr_wdata = req_q.wdata;
        if (!req_q.wr) begin
          rdata_d = i_sfr_rdata;
        end
        state_d = ST_RESP;
      end

      ST_EXT: begin
        o_ext_addr  = req_q.addr;
        o_ext_wdata = req_q.wdata;
        if (is_code && req_q.wr) begin
          // Program memory is read-only: burn the wait states with no
          // strobe and report the attempt as a bus error.
          if (ew_done) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          o_ext_psen = is_code;
          o_ext_re   = !is_code && !req_q.wr;
          o_ext_we   = !is_code && req_q.wr;
          // Ready wins over a timeout landing in the same cycle.
          if (ew_done && i_ext_rdy) begin
            if (!req_q.wr) begin
              rdata_d = i_ext_rdata;
            end
            state_d = ST_RESP;
          end else if (ew_timeout) begin
            if (!req_q.wr) begin
              rdata_d = 8'hFF;
            end
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        o_mem_ack = 1'b1;
        o_bus_err = err_q;
        if (iram_rd) begin
          o_mem_rdata = i_iram_rdata;
          rdata_d     = i_iram_rdata;
        end
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mc8051_mem_resp.sv
module tb_mc8051_mem_resp;

  localparam int CW  = 1;
  localparam int XW  = 2;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_mem_req, i_mem_wr;
  logic [1:0]  i_mem_space;
  logic [15:0] i_mem_addr;
  logic [7:0]  i_mem_wdata;
  logic        o_mem_busy, o_mem_ack, o_bus_err;
  logic [7:0]  o_mem_rdata;
  logic [7:0]  o_iram_addr, o_iram_wdata, i_iram_rdata;
  logic        o_iram_we, o_iram_re;
  logic [7:0]  o_sfr_addr, o_sfr_wdata, i_sfr_rdata;
  logic        o_sfr_we, o_sfr_re;
  logic [15:0] o_ext_addr;
  logic        o_ext_we, o_ext_re, o_ext_psen;
  logic [7:0]  o_ext_wdata, i_ext_rdata;
  logic        i_ext_rdy;

  int checks = 0;
  int errors = 0;

  // Reference contents (model side) and the memories the DUT actually sees.
  logic [7:0] ram_ref [0:255];
  logic [7:0] sfr_ref [0:255];
  logic [7:0] ram_dut [0:255];
  logic [7:0] sfr_dut [0:255];
  logic       seed_en;
  logic [7:0] iram_rd_q;
  logic [7:0] last_rdata;

  always #5 clk = ~clk;

  mc8051_mem_resp #(
    .CODE_WAIT(CW), .XDATA_WAIT(XW), .EXT_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_mem_req(i_mem_req), .i_mem_wr(i_mem_wr), .i_mem_space(i_mem_space),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .o_mem_busy(o_mem_busy), .o_mem_ack(o_mem_ack), .o_mem_rdata(o_mem_rdata),
    .o_bus_err(o_bus_err),
    .o_iram_addr(o_iram_addr), .o_iram_we(o_iram_we), .o_iram_re(o_iram_re),
    .o_iram_wdata(o_iram_wdata), .i_iram_rdata(i_iram_rdata),
    .o_sfr_addr(o_sfr_addr), .o_sfr_we(o_sfr_we), .o_sfr_re(o_sfr_re),
    .o_sfr_wdata(o_sfr_wdata), .i_sfr_rdata(i_sfr_rdata),
    .o_ext_addr(o_ext_addr), .o_ext_we(o_ext_we), .o_ext_re(o_ext_re),
    .o_ext_psen(o_ext_psen), .o_ext_wdata(o_ext_wdata),
    .i_ext_rdata(i_ext_rdata), .i_ext_rdy(i_ext_rdy)
  );

  // Synchronous internal RAM and combinational SFR file behind the DUT.
  always @(posedge clk) begin
    if (seed_en) begin
      for (int i = 0; i < 256; i++) begin
        ram_dut[i] <= ram_ref[i];
        sfr_dut[i] <= sfr_ref[i];
      end
    end else begin
      if (o_iram_re) iram_rd_q <= ram_dut[o_iram_addr];
      if (o_iram_we) ram_dut[o_iram_addr] <= o_iram_wdata;
      if (o_sfr_we)  sfr_dut[o_sfr_addr]  <= o_sfr_wdata;
    end
  end
  assign i_iram_rdata = iram_rd_q;
  assign i_sfr_rdata  = sfr_dut[o_sfr_addr];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 = internal RAM, 1 = SFR, 2 = external port.
  function automatic int target(input logic [1:0] sp, input logic [15:0] a);
    if (sp[1]) return 2;
    if (sp == 2'b01) return 0;
    return (a[7] == 1'b0) ? 0 : 1;
  endfunction

  // One access started in the cycle after the previous ack. delay = number
  // of ready-sampling cycles with i_ext_rdy low; spam keeps i_mem_req high
  // with junk while the DUT is busy.
  task automatic do_req(input logic wr, input logic [1:0] sp, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] xd,
                        input int delay, input bit spam);
    int p, wt, lat, nact;
    logic err_e;
    logic [7:0] rd_e;
    logic [2:0] ext_e;
    @(negedge clk);
    chk("idle_busy", o_mem_busy, 1'b0);
    chk("idle_ack", o_mem_ack, 1'b0);
    chk("rdata_hold", o_mem_rdata, last_rdata);
    for (int n = 0; n < 200 && o_mem_busy; n++) @(negedge clk);
    p  = target(sp, a);
    wt = (sp == 2'b10) ? CW : XW;
    err_e = 1'b0;
    rd_e  = last_rdata;
    if (p == 0) begin
      lat = 2; if (!wr) rd_e = ram_ref[a[7:0]];
    end else if (p == 1) begin
      lat = 2; if (!wr) rd_e = sfr_ref[a[7:0]];
    end else if (sp == 2'b10 && wr) begin
      lat = 2 + wt; err_e = 1'b1;
    end else if (wt + delay <= TMO - 1) begin
      lat = 2 + wt + delay; if (!wr) rd_e = xd;
    end else begin
      lat = TMO + 1; err_e = 1'b1; if (!wr) rd_e = 8'hFF;
    end
    ext_e = (sp == 2'b10) ? (wr ? 3'b000 : 3'b100) : (wr ? 3'b001 : 3'b010);

    i_mem_req = 1'b1; i_mem_wr = wr; i_mem_space = sp; i_mem_addr = a;
    i_mem_wdata = wd; i_ext_rdata = xd; i_ext_rdy = 1'b0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      nact = int'(o_iram_re | o_iram_we) + int'(o_sfr_re | o_sfr_we)
           + int'(o_ext_re | o_ext_we | o_ext_psen);
      chk("strobe_excl", nact <= 1, 1'b1);
      if (cyc < lat) begin
        chk("early_ack", o_mem_ack, 1'b0);
        chk("busy", o_mem_busy, 1'b1);
        if (p == 2) chk("ext_strobes", {o_ext_psen, o_ext_re, o_ext_we}, ext_e);
      end else begin
        chk("ack", o_mem_ack, 1'b1);
        chk("rdata", o_mem_rdata, rd_e);
        chk("bus_err", o_bus_err, err_e);
      end
      if (cyc == 1) begin
        if (p == 0) begin
          chk("iram_strobe", {o_iram_re, o_iram_we, o_iram_addr}, {!wr, wr, a[7:0]});
          if (wr) chk("iram_wdata", o_iram_wdata, wd);
        end else if (p == 1) begin
          chk("sfr_strobe", {o_sfr_re, o_sfr_we, o_sfr_addr}, {!wr, wr, a[7:0]});
          if (wr) chk("sfr_wdata", o_sfr_wdata, wd);
        end else begin
          chk("ext_addr", o_ext_addr, a);
          if (wr && sp == 2'b11) chk("ext_wdata", o_ext_wdata, wd);
        end
      end
      i_mem_req = spam;
      if (spam) begin
        i_mem_wr = 1'($urandom); i_mem_space = 2'($urandom);
        i_mem_addr = 16'($urandom); i_mem_wdata = 8'($urandom);
      end
      i_ext_rdy = (cyc >= 1 + wt + delay);
    end
    i_mem_req = 1'b0;
    i_ext_rdy = 1'b0;
    if (wr && p == 0) ram_ref[a[7:0]] = wd;
    if (wr && p == 1) sfr_ref[a[7:0]] = wd;
    last_rdata = rd_e;
  endtask

  initial begin
    logic [1:0] sp;
    i_rst = 1'b1; seed_en = 1'b1;
    i_mem_req = 1'b0; i_mem_wr = 1'b0; i_mem_space = 2'b00;
    i_mem_addr = '0; i_mem_wdata = '0; i_ext_rdata = '0; i_ext_rdy = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram_ref[i] = 8'($urandom);
      sfr_ref[i] = 8'($urandom);
    end
    ram_ref[8'h23] = 8'h5A;
    last_rdata = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        {o_mem_busy, o_mem_ack, o_mem_rdata, o_bus_err,
         o_iram_addr, o_iram_we, o_iram_re, o_iram_wdata,
         o_sfr_addr, o_sfr_we, o_sfr_re, o_sfr_wdata,
         o_ext_addr, o_ext_we, o_ext_re, o_ext_psen, o_ext_wdata}, '0);
    i_rst = 1'b0; seed_en = 1'b0;

    // Directed steps.
    do_req(1'b0, 2'b01, 16'h0023, 8'h00, 8'h00, 0, 1'b0);    // indirect read -> 5A
    do_req(1'b1, 2'b00, 16'h00E0, 8'h3C, 8'h00, 0, 1'b0);    // SFR write
    do_req(1'b0, 2'b00, 16'hFFE0, 8'h00, 8'h00, 0, 1'b0);    // SFR read back 3C
    do_req(1'b0, 2'b11, 16'h1234, 8'h00, 8'hA7, 0, 1'b0);    // xdata read, ack N+4
    do_req(1'b0, 2'b10, 16'h0100, 8'h00, 8'h96, 5, 1'b0);    // code read, ack N+8
    do_req(1'b0, 2'b10, 16'h0200, 8'h00, 8'h11, 1000, 1'b0); // code read timeout
    do_req(1'b1, 2'b10, 16'h0300, 8'h77, 8'h00, 0, 1'b0);    // code write -> error
    do_req(1'b1, 2'b11, 16'hBEEF, 8'hC4, 8'h00, 2, 1'b0);    // xdata write
    do_req(1'b1, 2'b00, 16'h127F, 8'hE1, 8'h00, 0, 1'b0);    // last direct RAM byte
    do_req(1'b0, 2'b00, 16'h007F, 8'h00, 8'h00, 0, 1'b1);    // read back, req spam
    do_req(1'b1, 2'b01, 16'h00FF, 8'h42, 8'h00, 0, 1'b1);    // indirect upper RAM
    do_req(1'b0, 2'b01, 16'hAAFF, 8'h00, 8'h00, 0, 1'b0);

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      sp = 2'($urandom);
      do_req(1'($urandom), sp, 16'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 15) == 0) ? 500 : int'($urandom_range(0, 4)),
             $urandom_range(0, 3) == 0);
    end

    // Reset in the second external wait cycle drops the access.
    @(negedge clk);
    i_mem_req = 1'b1; i_mem_wr = 1'b0; i_mem_space = 2'b11;
    i_mem_addr = 16'h4321; i_ext_rdy = 1'b0;
    @(negedge clk);
    i_mem_req = 1'b0;
    @(negedge clk);
    chk("rst_pre_ext_re", o_ext_re, 1'b1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs",
        {o_mem_busy, o_mem_ack, o_mem_rdata, o_bus_err,
         o_iram_we, o_iram_re, o_sfr_we, o_sfr_re,
         o_ext_we, o_ext_re, o_ext_psen}, '0);
    i_rst = 1'b0;
    last_rdata = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_ack", {o_mem_ack, o_mem_busy}, 2'b00);
    end
    do_req(1'b0, 2'b01, 16'h0023, 8'h00, 8'h00, 0, 1'b0);

    @(negedge clk);
    chk("final_idle", {o_mem_busy, o_mem_ack}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
